// File: rtl/udp_hdr_insert.sv
`default_nettype none
// ============================================================================
// Module   : udp_hdr_insert
// Brief    : Prepends an 8-byte UDP header to a 32-bit AXI-Stream payload.
// Revision : 1.0 - initial release
// ============================================================================
module udp_hdr_insert #(
  parameter int          MAX_LEN    = 1472,
  parameter logic [15:0] CSUM_VALUE = 16'h0000
) (
  input  logic        sclk,
  input  logic        reset_n,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic [31:0] s_axis_tdata,
  input  logic [3:0]  s_axis_tkeep,
  input  logic        s_axis_tlast,
  input  logic [63:0] s_axis_tuser,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [31:0] m_axis_tdata,
  output logic [3:0]  m_axis_tkeep,
  output logic        m_axis_tlast,
  output logic [15:0] m_axis_tuser,
  output logic        len_err,
  input  logic        len_err_clear,
  output logic [15:0] pkt_cnt
);

  localparam logic [2:0]  S_IDLE  = 3'd0;
  localparam logic [2:0]  S_HDR0  = 3'd1;
  localparam logic [2:0]  S_HDR1  = 3'd2;
  localparam logic [2:0]  S_PAY   = 3'd3;
  localparam logic [2:0]  S_DRAIN = 3'd4;
  localparam logic [15:0] c_max_len = 16'(MAX_LEN);

  logic [2:0]  r_state, w_next_state;
  logic [15:0] r_len, r_src, r_dst;
  logic [11:0] r_beat_cnt;
  logic        r_m_tvalid, r_m_tlast, r_len_err;
  logic [31:0] r_m_tdata;
  logic [3:0]  r_m_tkeep;
  logic [15:0] r_m_tuser, r_pkt_cnt;

  logic        w_m_free, w_m_hs, w_s_hs, w_s_ready;
  logic        w_ld_hdr0, w_ld_hdr1, w_done, w_start;
  logic [15:0] w_len_p8, w_new_len;
  logic [14:0] w_exp_beats, w_beat_num;
  logic        w_len_bad, w_cnt_bad, w_err_set;
  logic [3:0]  w_last_keep;
  logic        w_unused_ok;

  assign w_m_free = ~r_m_tvalid | m_axis_tready;
  assign w_m_hs   = r_m_tvalid & m_axis_tready;
  assign w_s_hs   = s_axis_tvalid & w_s_ready;
  assign w_start  = (r_state == S_IDLE) & s_axis_tvalid;
  assign w_len_p8 = r_len + 16'd8;

  // Length checks: bad sideband length is caught at latch time, beat-count
  // mismatch when the last payload beat is accepted.
  assign w_new_len   = s_axis_tuser[63:48];
  assign w_len_bad   = (w_new_len > c_max_len) | (w_new_len == 16'd0) | (w_new_len > 16'hFFF7);
  assign w_exp_beats = {1'b0, r_len[15:2]} + {14'd0, |r_len[1:0]};
  assign w_beat_num  = {3'd0, r_beat_cnt + 12'd1};
  assign w_cnt_bad   = w_s_hs & s_axis_tlast & (w_beat_num != w_exp_beats);
  assign w_err_set   = (w_start & w_len_bad) | w_cnt_bad;

  assign w_unused_ok = ^{s_axis_tkeep[3:2], s_axis_tuser[47:32]};

  always_comb begin
    w_last_keep = 4'hF;
    case (s_axis_tkeep[1:0])
      2'd1:    w_last_keep = 4'h8;
      2'd2:    w_last_keep = 4'hC;
      2'd3:    w_last_keep = 4'hE;
      default: w_last_keep = 4'hF;
    endcase
  end

  always_ff @(posedge sclk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (s_axis_tvalid)               w_next_state = S_HDR0;
      S_HDR0:  if (w_m_free)                    w_next_state = S_HDR1;
      S_HDR1:  if (w_m_free)                    w_next_state = S_PAY;
      S_PAY:   if (w_s_hs && s_axis_tlast)      w_next_state = S_DRAIN;
      S_DRAIN: if (w_m_hs && r_m_tlast)         w_next_state = S_IDLE;
      default:                                  w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_s_ready = 1'b0;
    w_ld_hdr0 = 1'b0;
    w_ld_hdr1 = 1'b0;
    w_done    = 1'b0;
    case (r_state)
      S_HDR0:  w_ld_hdr0 = w_m_free;
      S_HDR1:  w_ld_hdr1 = w_m_free;
      S_PAY:   w_s_ready = w_m_free;
      S_DRAIN: w_done    = w_m_hs & r_m_tlast;
      default: ;
    endcase
  end

  always_ff @(posedge sclk or negedge reset_n) begin
    if (!reset_n) begin
      r_len      <= 16'd0;
      r_src      <= 16'd0;
      r_dst      <= 16'd0;
      r_beat_cnt <= 12'd0;
    end else if (w_start) begin
      r_len      <= w_new_len;
      r_src      <= s_axis_tuser[31:16];
      r_dst      <= s_axis_tuser[15:0];
      r_beat_cnt <= 12'd0;
    end else if (w_s_hs) begin
      r_beat_cnt <= r_beat_cnt + 12'd1;
    end
  end

  // Single output register stage; holds its beat until the downstream takes it.
  always_ff @(posedge sclk or negedge reset_n) begin
    if (!reset_n) begin
      r_m_tvalid <= 1'b0;
      r_m_tdata  <= 32'd0;
      r_m_tkeep  <= 4'd0;
      r_m_tlast  <= 1'b0;
      r_m_tuser  <= 16'd0;
    end else if (w_ld_hdr0) begin
      r_m_tvalid <= 1'b1;
      r_m_tdata  <= {r_src, r_dst};
      r_m_tkeep  <= 4'hF;
      r_m_tlast  <= 1'b0;
      r_m_tuser  <= w_len_p8;
    end else if (w_ld_hdr1) begin
      r_m_tvalid <= 1'b1;
      r_m_tdata  <= {w_len_p8, CSUM_VALUE};
      r_m_tkeep  <= 4'hF;
      r_m_tlast  <= 1'b0;
    end else if (w_s_hs) begin
      r_m_tvalid <= 1'b1;
      r_m_tdata  <= s_axis_tdata;
      r_m_tkeep  <= s_axis_tlast ? w_last_keep : 4'hF;
      r_m_tlast  <= s_axis_tlast;
    end else if (w_m_hs) begin
      r_m_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge sclk or negedge reset_n) begin
    if (!reset_n) begin
      r_len_err <= 1'b0;
      r_pkt_cnt <= 16'd0;
    end else begin
      if (w_err_set)          r_len_err <= 1'b1;
      else if (len_err_clear) r_len_err <= 1'b0;
      if (w_done)             r_pkt_cnt <= r_pkt_cnt + 16'd1;
    end
  end

  assign s_axis_tready = w_s_ready;
  assign m_axis_tvalid = r_m_tvalid;
  assign m_axis_tdata  = r_m_tdata;
  assign m_axis_tkeep  = r_m_tkeep;
  assign m_axis_tlast  = r_m_tlast;
  assign m_axis_tuser  = r_m_tuser;
  assign len_err       = r_len_err;
  assign pkt_cnt       = r_pkt_cnt;

endmodule
`default_nettype wire
